// File: rtl/key_conditioner.sv
// Per-key push-button conditioning: 2-FF synchroniser, counter debouncer,
// press/release strobes and a one-shot long-press strobe. All outputs registered.
module key_conditioner #(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 500_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic [N_KEYS-1:0]     KEY,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     key_press,
  output logic [N_KEYS-1:0]     key_release,
  output logic [N_KEYS-1:0]     key_long,
  output logic [2*N_KEYS-1:0]   long_state
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HCW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    LP_IDLE  = 2'd0,
    LP_COUNT = 2'd1,
    LP_DONE  = 2'd2
  } lp_state_t;

  // Raw (active-low) key captured twice; reset value 1 means released.
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic            kn_s;
    logic            accept;
    logic [DBW-1:0]  dbc;
    logic [DBW-1:0]  dbc_next;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            long_q;
    lp_state_t       state;
    lp_state_t       state_next;
    logic [HCW-1:0]  hc;
    logic [HCW-1:0]  hc_next;
    logic            long_next;

    assign kn_s = ~sync2[i];

    // A change is taken on the DB_CYCLES-th consecutive differing sample.
    always_comb begin
      accept   = 1'b0;
      dbc_next = '0;
      if (kn_s != level_q) begin
        if (dbc == DB_LAST) begin
          accept = 1'b1;
        end else begin
          dbc_next = dbc + DBW'(1);
        end
      end
    end

    always_comb begin
      state_next = state;
      hc_next    = hc;
      long_next  = 1'b0;
      if (accept && !kn_s) begin
        state_next = LP_IDLE;
        hc_next    = '0;
      end else begin
        case (state)
          LP_IDLE: begin
            hc_next = '0;
            if (accept && kn_s) state_next = LP_COUNT;
          end
          LP_COUNT: begin
            if (hc == HC_LAST) begin
              long_next  = 1'b1;
              state_next = LP_DONE;
            end else begin
              hc_next = hc + HCW'(1);
            end
          end
          LP_DONE: ;
          default: begin
            state_next = LP_IDLE;
            hc_next    = '0;
          end
        endcase
      end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        dbc       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        state     <= LP_IDLE;
        hc        <= '0;
      end else begin
        dbc       <= dbc_next;
        level_q   <= accept ? kn_s : level_q;
        press_q   <= accept & kn_s;
        release_q <= accept & ~kn_s;
        long_q    <= long_next;
        state     <= state_next;
        hc        <= hc_next;
      end
    end

    assign key_level[i]          = level_q;
    assign key_press[i]          = press_q;
    assign key_release[i]        = release_q;
    assign key_long[i]           = long_q;
    assign long_state[2*i +: 2]  = state;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce / long-press windows.
module tb_key_conditioner;

  localparam int NK = 4;

  logic            CLOCK_50;
  logic            reset_n;
  logic [NK-1:0]   KEY;
  logic [NK-1:0]   key_level;
  logic [NK-1:0]   key_press;
  logic [NK-1:0]   key_release;
  logic [NK-1:0]   key_long;
  logic [2*NK-1:0] long_state;

  key_conditioner #(
    .N_KEYS(NK),
    .DB_CYCLES(8),
    .LONG_CYCLES(32)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n(reset_n),
    .KEY(KEY),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long),
    .long_state(long_state)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // strobe counters and width / exclusivity monitor
  int press_cnt [NK];
  int rel_cnt   [NK];
  int long_cnt  [NK];
  logic [NK-1:0] prev_press = '0;
  logic [NK-1:0] prev_rel   = '0;
  logic [NK-1:0] prev_long  = '0;

  initial begin
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
      long_cnt[k]  = 0;
    end
  end

  always @(negedge CLOCK_50) begin
    check("strobe_shape", 32'((key_press & key_release) | (key_press & prev_press) |
                              (key_release & prev_rel) | (key_long & prev_long)), 32'd0);
    for (int k = 0; k < NK; k++) begin
      if (key_press[k])   press_cnt[k]++;
      if (key_release[k]) rel_cnt[k]++;
      if (key_long[k])    long_cnt[k]++;
    end
    prev_press = key_press;
    prev_rel   = key_release;
    prev_long  = key_long;
  end

  typedef struct {
    logic          rst;
    logic [NK-1:0] key;
    int            n;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
    logic [NK-1:0] lng;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;

  task automatic add(input logic r, input logic [NK-1:0] k, input int n,
                     input logic [NK-1:0] l, input logic [NK-1:0] p,
                     input logic [NK-1:0] rl, input logic [NK-1:0] lg);
    vecs[nv].rst = r;
    vecs[nv].key = k;
    vecs[nv].n   = n;
    vecs[nv].lvl = l;
    vecs[nv].prs = p;
    vecs[nv].rel = rl;
    vecs[nv].lng = lg;
    nv++;
  endtask

  int exp_press [NK];
  int exp_rel   [NK];
  int exp_long  [NK];

  initial begin
    reset_n = 1'b0;
    KEY     = 4'hF;

    // reset and idle
    add(0, 4'hF, 3,  4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 5,  4'h0, 4'h0, 4'h0, 4'h0);
    // clean press of key 0, long press, release
    add(1, 4'hE, 9,  4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 1,  4'h1, 4'h1, 4'h0, 4'h0);
    add(1, 4'hE, 1,  4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 30, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 1,  4'h1, 4'h0, 4'h0, 4'h1);
    add(1, 4'hE, 1,  4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 20, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 9,  4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 1,  4'h0, 4'h0, 4'h1, 4'h0);
    add(1, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0);
    // key 3 held 20 cycles then released: no long press
    add(1, 4'h7, 10, 4'h8, 4'h8, 4'h0, 4'h0);
    add(1, 4'h7, 20, 4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 9,  4'h8, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 1,  4'h0, 4'h0, 4'h8, 4'h0);
    add(1, 4'hF, 40, 4'h0, 4'h0, 4'h0, 4'h0);
    // all keys together
    add(1, 4'h0, 9,  4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 1,  4'hF, 4'hF, 4'h0, 4'h0);
    add(1, 4'hF, 9,  4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 1,  4'h0, 4'h0, 4'hF, 4'h0);
    add(1, 4'hF, 3,  4'h0, 4'h0, 4'h0, 4'h0);

    for (int v = 0; v < nv; v++) begin
      reset_n = vecs[v].rst;
      KEY     = vecs[v].key;
      tick(vecs[v].n);
      check($sformatf("v%0d_level", v),   32'(key_level),   32'(vecs[v].lvl));
      check($sformatf("v%0d_press", v),   32'(key_press),   32'(vecs[v].prs));
      check($sformatf("v%0d_release", v), 32'(key_release), 32'(vecs[v].rel));
      check($sformatf("v%0d_long", v),    32'(key_long),    32'(vecs[v].lng));
    end

    // bouncing key 1: only the final steady low is accepted
    for (int r = 0; r < 4; r++) begin
      KEY = 4'hD;
      tick(5);
      KEY = 4'hF;
      tick(2);
    end
    check("bounce_no_early_press", 32'(press_cnt[1]), 32'd1);
    KEY = 4'hD;
    tick(9);
    check("bounce_level_9", 32'(key_level), 32'h0);
    tick(1);
    check("bounce_level_10", 32'(key_level), 32'h2);
    check("bounce_press_10", 32'(key_press), 32'h2);
    tick(2);
    check("bounce_press_cnt", 32'(press_cnt[1]), 32'd2);
    KEY = 4'hF;
    tick(10);
    check("bounce_release", 32'(key_release), 32'h2);
    tick(2);

    // 7-cycle glitch is one sample short of acceptance
    KEY = 4'hD;
    tick(7);
    KEY = 4'hF;
    tick(20);
    check("glitch_level", 32'(key_level), 32'h0);
    check("glitch_press_cnt", 32'(press_cnt[1]), 32'd2);

    // reset while key 2 sits in the long-press done state
    KEY = 4'hB;
    tick(10);
    check("rst_pre_press", 32'(key_press), 32'h4);
    tick(32);
    check("rst_pre_long", 32'(key_long), 32'h4);
    tick(5);
    check("rst_pre_state_done", 32'(long_state[5:4]), 32'd2);
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs", {key_level, key_press, key_release, key_long}, 32'h0);
    check("rst_async_state", 32'(long_state), 32'h0);
    tick(3);
    check("rst_hold_outputs", {key_level, key_press, key_release, key_long}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    check("rst_release_cycle", {key_level, key_press, key_release, key_long}, 32'h0);
    tick(8);
    check("rst_redetect_9", 32'(key_level), 32'h0);
    tick(1);
    check("rst_redetect_level", 32'(key_level), 32'h4);
    check("rst_redetect_press", 32'(key_press), 32'h4);
    tick(31);
    check("rst_long_31", 32'(key_long), 32'h0);
    tick(1);
    check("rst_long_32", 32'(key_long), 32'h4);
    tick(1);
    check("rst_long_33", 32'(key_long), 32'h0);
    KEY = 4'hF;
    tick(10);
    check("rst_final_release", 32'(key_release), 32'h4);
    tick(3);

    // cumulative strobe counts
    exp_press = '{2, 2, 3, 2};
    exp_rel   = '{2, 2, 2, 2};
    exp_long  = '{1, 0, 2, 0};
    for (int k = 0; k < NK; k++) begin
      check($sformatf("press_cnt_%0d", k),   32'(press_cnt[k]), 32'(exp_press[k]));
      check($sformatf("release_cnt_%0d", k), 32'(rel_cnt[k]),   32'(exp_rel[k]));
      check($sformatf("long_cnt_%0d", k),    32'(long_cnt[k]),  32'(exp_long[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
